// File: rtl/frame_descrambler_par_if.sv
// Handshake/bus bundle for the parallel frame descrambler: beat input, flush,
// descrambled beat output and the parsed-header status.
interface frame_descrambler_par_if #(
  parameter int W     = 1,
  parameter int LEN_W = 12
);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             flush;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [LEN_W-1:0] hdr_len;
  logic             hdr_valid;
  logic             hdr_err;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, flush,
    input  out_valid, out_data, out_last, hdr_len, hdr_valid, hdr_err, busy, done
  );

  modport slave (
    input  in_valid, in_data, flush,
    output out_valid, out_data, out_last, hdr_len, hdr_valid, hdr_err, busy, done
  );
endinterface

// File: rtl/frame_descrambler_par.sv
// Receive-side frame descrambler: parses SIGNAL/SERVICE/DATA, recovers the
// x^7+x^4+1 seed from SERVICE and descrambles DATA, W bits per beat.
module frame_descrambler_par #(
  parameter int W     = 1,
  parameter int LEN_W = 12
) (
  input logic                    clk,
  input logic                    rst,
  frame_descrambler_par_if.slave bus
);
  localparam int CW = LEN_W + 4;

  typedef enum logic [2:0] {IDLE, SIGNAL, SERVICE, DATA, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:1]       seed_q, seed_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             par_q, par_d;
  logic             hv_q, hv_d;
  logic             herr_q, herr_d;
  logic             ov_q, ov_d;
  logic [W-1:0]     od_q, od_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  always_comb begin
    logic [CW-1:0]    cnt_b, cnt_nx, data_end;
    logic [LEN_W-1:0] len_b;
    logic [7:1]       s;
    logic             par_b, k;
    int               p;
    state_d  = state_q;
    cnt_d    = cnt_q;
    seed_d   = seed_q;
    len_d    = len_q;
    par_d    = par_q;
    hv_d     = hv_q;
    herr_d   = herr_q;
    ov_d     = 1'b0;
    od_d     = '0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    // An IDLE beat is the first SIGNAL beat, so it starts from cleared header state
    cnt_b    = (state_q == IDLE) ? '0   : cnt_q;
    len_b    = (state_q == IDLE) ? '0   : len_q;
    par_b    = (state_q == IDLE) ? 1'b0 : par_q;
    cnt_nx   = cnt_b + CW'(W);
    data_end = CW'(40) + CW'({len_q, 3'b000});
    s        = seed_q;
    k        = 1'b0;
    p        = 0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      hv_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, SIGNAL: if (bus.in_valid) begin
          if (state_q == IDLE) begin
            herr_d = 1'b0;
            hv_d   = 1'b0;
          end
          for (int j = 0; j < W; j++) begin
            p = int'(cnt_b) + j;
            if (p >= 5 && p <= 16) len_b |= LEN_W'(bus.in_data[j]) << (p - 5);
            if (p <= 17) par_b ^= bus.in_data[j];
          end
          len_d = len_b;
          par_d = par_b;
          cnt_d = cnt_nx;
          ov_d  = 1'b1;
          od_d  = bus.in_data;
          if (cnt_nx == CW'(24)) begin
            state_d = SERVICE;
            hv_d    = 1'b1;
            herr_d  = par_b;
          end else begin
            state_d = SIGNAL;
          end
        end
        SERVICE: if (bus.in_valid) begin
          for (int j = 0; j < W; j++) s = {s[6:1], bus.in_data[j]};
          seed_d = s;
          cnt_d  = cnt_nx;
          if (cnt_nx == CW'(40)) state_d = (len_q == '0) ? DONE : DATA;
        end
        DATA: if (bus.in_valid) begin
          // Bits are descrambled serially in arrival order so any W matches W=1
          for (int j = 0; j < W; j++) begin
            k       = s[4] ^ s[7];
            od_d[j] = bus.in_data[j] ^ k;
            s       = {s[6:1], k};
          end
          seed_d = s;
          cnt_d  = cnt_nx;
          ov_d   = 1'b1;
          if (cnt_nx == data_end) begin
            last_d  = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          done_d  = 1'b1;
          hv_d    = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seed_q  <= '0;
      len_q   <= '0;
      par_q   <= 1'b0;
      hv_q    <= 1'b0;
      herr_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      par_q   <= par_d;
      hv_q    <= hv_d;
      herr_q  <= herr_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_last  = last_q;
  assign bus.hdr_len   = len_q;
  assign bus.hdr_valid = hv_q;
  assign bus.hdr_err   = herr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_frame_descrambler_par.sv
// Directed bench: frames are built with a transmit-side scrambler and the
// descrambled output is compared with the plaintext, at W=1, 4 and 8.
module tb_frame_descrambler_par;
  logic clk;
  logic rst;
  int   cyc;
  int   act;
  int   n_chk, n_fail;

  frame_descrambler_par_if #(.W(1), .LEN_W(12)) i1 ();
  frame_descrambler_par_if #(.W(4), .LEN_W(12)) i4 ();
  frame_descrambler_par_if #(.W(8), .LEN_W(12)) i8 ();

  frame_descrambler_par #(.W(1), .LEN_W(12)) u1 (.clk(clk), .rst(rst), .bus(i1));
  frame_descrambler_par #(.W(4), .LEN_W(12)) u4 (.clk(clk), .rst(rst), .bus(i4));
  frame_descrambler_par #(.W(8), .LEN_W(12)) u8 (.clk(clk), .rst(rst), .bus(i8));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_valid, m_last, m_hv, m_herr, m_busy, m_done;
  logic [7:0]  m_data;
  logic [11:0] m_len;

  always_comb begin
    m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_len = '0;
    m_hv = 1'b0; m_herr = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    case (act)
      1: begin
        m_valid = i1.out_valid; m_data = 8'(i1.out_data); m_last = i1.out_last; m_len = i1.hdr_len;
        m_hv = i1.hdr_valid; m_herr = i1.hdr_err; m_busy = i1.busy; m_done = i1.done;
      end
      4: begin
        m_valid = i4.out_valid; m_data = 8'(i4.out_data); m_last = i4.out_last; m_len = i4.hdr_len;
        m_hv = i4.hdr_valid; m_herr = i4.hdr_err; m_busy = i4.busy; m_done = i4.done;
      end
      default: begin
        m_valid = i8.out_valid; m_data = i8.out_data; m_last = i8.out_last; m_len = i8.hdr_len;
        m_hv = i8.hdr_valid; m_herr = i8.hdr_err; m_busy = i8.busy; m_done = i8.done;
      end
    endcase
  end

  logic        fbits[$];
  logic        ebits[$];
  logic        obits[$];
  int          nbeats, nlast, last_beat, ndone, done_cyc, last_cyc;
  logic        p_hv, p_herr, s_hv, s_herr;
  logic [11:0] p_len, s_len;

  // Monitor: collect output bits and snapshot header state the cycle before done
  always @(negedge clk) begin
    if (m_valid) begin
      for (int j = 0; j < act; j++) obits.push_back(m_data[j]);
      nbeats++;
      if (m_last) begin nlast++; last_beat = nbeats; end
    end
    if (m_done) begin
      ndone++; done_cyc = cyc; s_hv = p_hv; s_len = p_len; s_herr = p_herr;
    end
    p_hv = m_hv; p_len = m_len; p_herr = m_herr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic [7:0] d, input logic v, input logic f);
    i1.in_valid = (w == 1) && v; i1.in_data = d[0:0]; i1.flush = (w == 1) && f;
    i4.in_valid = (w == 4) && v; i4.in_data = d[3:0]; i4.flush = (w == 4) && f;
    i8.in_valid = (w == 8) && v; i8.in_data = d;      i8.flush = (w == 8) && f;
  endtask

  // SIGNAL with even parity in bit 17, SERVICE = scrambled zeros, DATA scrambled
  task automatic build(input int len, input bit flip, input int dseed);
    logic [23:0] sig;
    logic [7:1]  x;
    logic        k;
    logic [7:0]  b;
    fbits.delete(); ebits.delete();
    sig = '0;
    sig[3:0] = 4'b1011;
    for (int i = 0; i < 12; i++) sig[5+i] = len[i];
    sig[17] = ^sig[16:0];
    if (flip) sig[17] = ~sig[17];
    for (int i = 0; i < 24; i++) begin fbits.push_back(sig[i]); ebits.push_back(sig[i]); end
    x = 7'b1011101;
    for (int i = 0; i < 16; i++) begin
      k = x[4] ^ x[7]; x = {x[6:1], k}; fbits.push_back(k);
    end
    for (int i = 0; i < len; i++) begin
      b = 8'((i * 37 + dseed) & 255);
      for (int j = 0; j < 8; j++) begin
        k = x[4] ^ x[7]; x = {x[6:1], k};
        fbits.push_back(b[j] ^ k); ebits.push_back(b[j]);
      end
    end
  endtask

  function automatic logic [7:0] beat(input int w, input int b);
    logic [7:0] d;
    d = '0;
    for (int j = 0; j < w; j++) d[j] = fbits[b*w + j];
    return d;
  endfunction

  // Drives beats [0, stop_at) (all if stop_at<0), optional idle gaps during DATA
  task automatic run_frame(input int w, input bit gaps, input int stop_at);
    int nb;
    nb = fbits.size() / w;
    act = w;
    obits.delete();
    nbeats = 0; nlast = 0; last_beat = 0; ndone = 0; done_cyc = 0;
    for (int b = 0; b < nb; b++) begin
      if (stop_at >= 0 && b == stop_at) return;
      if (gaps && b >= 40 / w)
        for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
          drive(w, 8'h00, 1'b0, 1'b0); @(negedge clk);
        end
      drive(w, beat(w, b), 1'b1, 1'b0);
      last_cyc = cyc;
      @(negedge clk);
    end
    drive(w, 8'h00, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_frame(input int w, input int len, input bit flip, input string tag);
    logic [7:0] g, e;
    int         nexp;
    nexp = 24 / w + (8 * len) / w;
    chk({tag, "/nbits"}, obits.size(), ebits.size());
    for (int i = 0; i + 8 <= ebits.size() && i + 8 <= obits.size(); i += 8) begin
      for (int j = 0; j < 8; j++) begin g[j] = obits[i+j]; e[j] = ebits[i+j]; end
      chk($sformatf("%s/byte%0d", tag, i / 8), g, e);
    end
    chk({tag, "/hdr_len"}, s_len, len);
    chk({tag, "/hdr_valid"}, s_hv, 1);
    chk({tag, "/hdr_err"}, s_herr, flip);
    chk({tag, "/ndone"}, ndone, 1);
    chk({tag, "/nlast"}, nlast, (len > 0) ? 1 : 0);
    chk({tag, "/last_beat"}, last_beat, (len > 0) ? nexp : 0);
    chk({tag, "/nbeats"}, nbeats, nexp);
    chk({tag, "/done_lat"}, done_cyc - last_cyc, 2);
    chk({tag, "/busy_after"}, m_busy, 0);
    chk({tag, "/hv_after"}, m_hv, 0);
    chk({tag, "/herr_held"}, m_herr, flip);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; act = 8;
    rst = 1'b1;
    drive(8, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst/out_valid", m_valid, 0);
    chk("rst/out_data", m_data, 0);
    chk("rst/out_last", m_last, 0);
    chk("rst/hdr", {m_hv, m_herr, m_len}, 0);
    chk("rst/busy_done", {m_busy, m_done}, 0);
    rst = 1'b0;
    @(negedge clk);

    build(1, 1'b0, 11);   run_frame(1, 1'b0, -1); check_frame(1, 1, 1'b0, "w1_len1");
    build(100, 1'b0, 3);  run_frame(4, 1'b0, -1); check_frame(4, 100, 1'b0, "w4_len100");
    build(0, 1'b0, 0);    run_frame(8, 1'b0, -1); check_frame(8, 0, 1'b0, "w8_len0");
    build(3, 1'b1, 5);    run_frame(8, 1'b0, -1); check_frame(8, 3, 1'b1, "w8_parerr");
    build(2, 1'b0, 9);    run_frame(8, 1'b0, -1); check_frame(8, 2, 1'b0, "w8_after_err");
    build(20, 1'b0, 21);  run_frame(8, 1'b1, -1); check_frame(8, 20, 1'b0, "w8_gaps");
    build(20, 1'b0, 21);  run_frame(1, 1'b0, -1); check_frame(1, 20, 1'b0, "w1_len20");

    // Asynchronous reset while DATA beat 10 is presented
    build(20, 1'b0, 33);  run_frame(8, 1'b0, 14);
    drive(8, beat(8, 14), 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst/out_valid", m_valid, 0);
    chk("midrst/busy", m_busy, 0);
    chk("midrst/hdr", {m_hv, m_herr, m_len}, 0);
    @(negedge clk);
    drive(8, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    build(5, 1'b0, 77);   run_frame(8, 1'b0, -1); check_frame(8, 5, 1'b0, "after_rst");

    // Flush together with DATA beat 10: beat dropped, IDLE, no done pulse
    build(20, 1'b0, 44);  run_frame(8, 1'b0, 14);
    drive(8, beat(8, 14), 1'b1, 1'b1);
    @(negedge clk);
    drive(8, 8'h00, 1'b0, 1'b0);
    chk("flush/out_valid", m_valid, 0);
    chk("flush/busy", m_busy, 0);
    chk("flush/hdr_valid", m_hv, 0);
    chk("flush/nbeats", nbeats, 3 + 9);
    repeat (4) @(negedge clk);
    chk("flush/ndone", ndone, 0);
    build(4, 1'b0, 55);   run_frame(8, 1'b0, -1); check_frame(8, 4, 1'b0, "after_flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
